fp_add_seq: RTL and testbench

FP_ADD_SEQ -- requirements
Module: fp_add_seq

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fp_add_seq.sv | 119 +++++++++++
 tb/tb_fp_add_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode codes, special single-precision encodings,
// sequencer state encoding and small helpers.
package fpu_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned EXP_W = 8;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RZ  = 3'b001;
  localparam logic [2:0] RM_RD  = 3'b010;
  localparam logic [2:0] RM_RU  = 3'b011;
  localparam logic [2:0] RM_RNA = 3'b100;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [FP_W-1:0] FP_NEG_INF  = 32'hFF80_0000;
  localparam logic [FP_W-1:0] FP_QNAN     = 32'h7FC0_0000;

  // Flag vector order is {inv, ov, un, inexact}
  localparam logic [3:0] FLAG_INV = 4'b1000;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

  // Reserved rounding codes collapse to round-to-nearest-even
  function automatic logic [2:0] legal_rm(input logic [2:0] rm);
    return (rm <= RM_RNA) ? rm : RM_RNE;
  endfunction

endpackage

// File: rtl/fp_add_seq.sv
// Request/response sequencer around an external fixed-latency FP adder.
// Optional FP_ADD_SEQ_SUB_EN turns op_sub into a sign flip of operand 2 (NaN excepted).
module fp_add_seq
  import fpu_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned ADD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_in1,
  input  logic [W-1:0] req_in2,
  input  logic [2:0]   req_round_m,
  input  logic         op_sub,
  output logic [W-1:0] a_in1,
  output logic [W-1:0] a_in2,
  output logic [2:0]   a_round_m,
  input  logic [W-1:0] a_out,
  input  logic         a_ov,
  input  logic         a_un,
  input  logic         a_inv,
  input  logic         a_inexact,
  input  logic         a_done,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_out,
  output logic [3:0]   res_flags,
  output logic [3:0]   fflags,
  input  logic         clr_flags,
  output logic         busy
);

  localparam int unsigned CNT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
  localparam int unsigned MAN_W = W - EXP_W - 1;

  logic [ST_W-1:0]  state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [W-1:0]     a_in1_d, a_in2_d, res_out_d, in2_eff;
  logic [2:0]       rm_d;
  logic [3:0]       res_flags_d, fflags_d;

`ifdef FP_ADD_SEQ_SUB_EN
  logic in2_is_nan;
  assign in2_is_nan = (&req_in2[W-2 -: EXP_W]) && (|req_in2[MAN_W-1:0]);
  assign in2_eff    = (op_sub && !in2_is_nan) ? {~req_in2[W-1], req_in2[W-2:0]} : req_in2;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign in2_eff       = req_in2;
`endif

  // Next-state and next-register values
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    a_in1_d     = a_in1;
    a_in2_d     = a_in2;
    rm_d        = a_round_m;
    res_out_d   = res_out;
    res_flags_d = res_flags;
    fflags_d    = clr_flags ? 4'b0000 : fflags;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(ADD_LAT);
          a_in1_d = req_in1;
          a_in2_d = in2_eff;
          rm_d    = legal_rm(req_round_m);
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(0)) begin
          state_d     = ST_RESP;
          res_out_d   = a_done ? a_out : W'(FP_QNAN);
          res_flags_d = a_done ? {a_inv, a_ov, a_un, a_inexact} : FLAG_INV;
          fflags_d    = fflags_d | res_flags_d;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_in1     <= '0;
      a_in2     <= '0;
      a_round_m <= RM_RNE;
      res_out   <= '0;
      res_flags <= '0;
      fflags    <= '0;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      a_in1     <= a_in1_d;
      a_in2     <= a_in2_d;
      a_round_m <= rm_d;
      res_out   <= res_out_d;
      res_flags <= res_flags_d;
      fflags    <= fflags_d;
      req_ready <= (state_d == ST_IDLE);
      res_valid <= (state_d == ST_RESP);
      busy      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq with a small table-driven adder model of latency ADD_LAT.
module tb_fp_add_seq;

  localparam int unsigned W       = 32;
  localparam int unsigned ADD_LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [W-1:0] req_in1, req_in2;
  logic [2:0]   req_round_m;
  logic         op_sub;
  logic [W-1:0] a_in1, a_in2, a_out;
  logic [2:0]   a_round_m;
  logic         a_ov, a_un, a_inv, a_inexact, a_done;
  logic         res_valid, res_ready;
  logic [W-1:0] res_out;
  logic [3:0]   res_flags, fflags;
  logic         clr_flags, busy;
  logic         force_nd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_add_seq #(.W(W), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_round_m(req_round_m), .op_sub(op_sub),
    .a_in1(a_in1), .a_in2(a_in2), .a_round_m(a_round_m),
    .a_out(a_out), .a_ov(a_ov), .a_un(a_un), .a_inv(a_inv), .a_inexact(a_inexact),
    .a_done(a_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
    .res_flags(res_flags), .fflags(fflags), .clr_flags(clr_flags), .busy(busy)
  );

  // Known sums, flags {inv,ov,un,inexact}
  function automatic logic [35:0] add_model(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h3F800000 && y == 32'h40000000) return {4'b0000, 32'h40400000};
    if (x == 32'h7F800000 && y == 32'hFF800000) return {4'b1000, 32'h7FC00000};
    if (x == 32'h40400000 && y == 32'hBF800000) return {4'b0000, 32'h40000000};
    if (x == 32'h40400000 && y == 32'h3F800000) return {4'b0000, 32'h40800000};
    return {4'b0000, 32'h00000000};
  endfunction

  logic [35:0] pipe [ADD_LAT];
  always @(posedge clk) begin
    pipe[0] <= add_model(a_in1, a_in2);
    for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {a_inv, a_ov, a_un, a_inexact} = pipe[ADD_LAT-1][35:32];
  assign a_out  = pipe[ADD_LAT-1][31:0];
  assign a_done = ~force_nd;

  task automatic do_accept(input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] rm, input logic sub);
    @(negedge clk);
    req_in1 = x; req_in2 = y; req_round_m = rm; op_sub = sub; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Returns clocks from accept until res_valid, or -1 if the bound expires
  task automatic wait_res(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (res_valid) begin lat = k; break; end
    end
  endtask

  task automatic take_resp();
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl busy=%b res_valid=%b required 0/0", busy, res_valid); end
    checks++; if (a_in1 !== 32'h0 || a_in2 !== 32'h0 || res_out !== 32'h0 || a_round_m !== 3'b000) begin errors++;
      $display("FAIL reset_data a_in1=%h a_in2=%h res_out=%h rm=%b required zeros", a_in1, a_in2, res_out, a_round_m); end
    checks++; if (res_flags !== 4'h0 || fflags !== 4'h0) begin errors++;
      $display("FAIL reset_flags res_flags=%b fflags=%b required 0", res_flags, fflags); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready req_ready=%b required 1", req_ready); end
  endtask

  task automatic test_add_basic();
    int lat;
    do_accept(32'h3F800000, 32'h40000000, 3'b000, 1'b0);
    checks++; if (req_ready !== 1'b0 || busy !== 1'b1 || a_in1 !== 32'h3F800000 || a_in2 !== 32'h40000000) begin errors++;
      $display("FAIL add_accept ready=%b busy=%b a_in1=%h a_in2=%h required 0/1/3f800000/40000000",
               req_ready, busy, a_in1, a_in2); end
    wait_res(lat);
    checks++; if (lat != ADD_LAT + 1) begin errors++;
      $display("FAIL add_latency got %0d required %0d", lat, ADD_LAT + 1); end
    checks++; if (res_out !== 32'h40400000 || res_flags !== 4'b0000) begin errors++;
      $display("FAIL add_result res_out=%h flags=%b required 40400000/0000", res_out, res_flags); end
    take_resp();
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL add_release valid=%b ready=%b busy=%b required 0/1/0", res_valid, req_ready, busy); end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    do_accept(32'h3F800000, 32'h40000000, 3'b000, 1'b0);
    wait_res(lat);
    checks++; if (lat != ADD_LAT + 1) begin errors++;
      $display("FAIL bp_latency got %0d required %0d", lat, ADD_LAT + 1); end
    @(negedge clk);
    req_in1 = 32'h40400000; req_in2 = 32'h3F800000; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_out !== 32'h40400000 ||
          res_flags !== 4'b0000 || a_in1 !== 32'h3F800000) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL bp_hold %0d unstable cycles required 0 (res_out=%h a_in1=%h ready=%b)",
               bad, res_out, a_in1, req_ready); end
    @(negedge clk); req_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release valid=%b ready=%b required 0/1", res_valid, req_ready); end
  endtask

  task automatic test_inf_flags();
    int lat;
    do_accept(32'h7F800000, 32'hFF800000, 3'b000, 1'b0);
    wait_res(lat);
    checks++; if (res_out !== 32'h7FC00000 || res_flags !== 4'b1000 || fflags !== 4'b1000) begin errors++;
      $display("FAIL inf_result res_out=%h flags=%b fflags=%b required 7fc00000/1000/1000",
               res_out, res_flags, fflags); end
    take_resp();
    @(negedge clk); clr_flags = 1'b1;
    @(posedge clk); #1; clr_flags = 1'b0;
    checks++; if (fflags !== 4'b0000) begin errors++;
      $display("FAIL clr_flags fflags=%b required 0000", fflags); end
    do_accept(32'h7F800000, 32'hFF800000, 3'b000, 1'b0);
    for (int k = 1; k <= ADD_LAT; k++) @(posedge clk);
    @(negedge clk); clr_flags = 1'b1;
    @(posedge clk); #1; clr_flags = 1'b0;
    checks++; if (res_valid !== 1'b1 || fflags !== 4'b1000) begin errors++;
      $display("FAIL clr_at_capture valid=%b fflags=%b required 1/1000", res_valid, fflags); end
    take_resp();
  endtask

  task automatic test_round_and_notdone();
    int lat;
    do_accept(32'h3F800000, 32'h40000000, 3'b111, 1'b0);
    checks++; if (a_round_m !== 3'b000) begin errors++;
      $display("FAIL rm_reserved a_round_m=%b required 000", a_round_m); end
    force_nd = 1'b1;
    wait_res(lat);
    force_nd = 1'b0;
    checks++; if (res_out !== 32'h7FC00000 || res_flags !== 4'b1000) begin errors++;
      $display("FAIL not_done res_out=%h flags=%b required 7fc00000/1000", res_out, res_flags); end
    take_resp();
    do_accept(32'h3F800000, 32'h40000000, 3'b100, 1'b0);
    checks++; if (a_round_m !== 3'b100) begin errors++;
      $display("FAIL rm_rna a_round_m=%b required 100", a_round_m); end
    wait_res(lat);
    take_resp();
    do_accept(32'h3F800000, 32'h40000000, 3'b011, 1'b0);
    checks++; if (a_round_m !== 3'b011) begin errors++;
      $display("FAIL rm_ru a_round_m=%b required 011", a_round_m); end
    wait_res(lat);
    take_resp();
  endtask

  task automatic test_reset_mid_wait();
    int seen = 0;
    do_accept(32'h3F800000, 32'h40000000, 3'b010, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1 ||
                  a_in1 !== 32'h0 || a_in2 !== 32'h0 || a_round_m !== 3'b000) begin errors++;
      $display("FAIL rst_mid_wait busy=%b valid=%b ready=%b a_in1=%h a_in2=%h rm=%b required 0/0/1/0/0/000",
               busy, res_valid, req_ready, a_in1, a_in2, a_round_m); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++;
      $display("FAIL rst_no_result saw activity in %0d cycles required 0", seen); end
  endtask

  task automatic test_sub();
    int lat;
    logic [31:0] exp_in2, exp_out;
`ifdef FP_ADD_SEQ_SUB_EN
    exp_in2 = 32'hBF800000; exp_out = 32'h40000000;
`else
    exp_in2 = 32'h3F800000; exp_out = 32'h40800000;
`endif
    do_accept(32'h40400000, 32'h3F800000, 3'b000, 1'b1);
    checks++; if (a_in2 !== exp_in2) begin errors++;
      $display("FAIL sub_operand a_in2=%h required %h", a_in2, exp_in2); end
    wait_res(lat);
    checks++; if (lat != ADD_LAT + 1 || res_out !== exp_out) begin errors++;
      $display("FAIL sub_result lat=%0d res_out=%h required %0d/%h", lat, res_out, ADD_LAT + 1, exp_out); end
    take_resp();
    do_accept(32'h40400000, 32'h7FC00001, 3'b000, 1'b1);
    checks++; if (a_in2 !== 32'h7FC00001) begin errors++;
      $display("FAIL sub_nan a_in2=%h required 7fc00001", a_in2); end
    wait_res(lat);
    take_resp();
  endtask

  initial begin
    req_valid = 1'b0; req_in1 = '0; req_in2 = '0; req_round_m = 3'b000; op_sub = 1'b0;
    res_ready = 1'b0; clr_flags = 1'b0; force_nd = 1'b0; rst = 1'b1;
    test_reset();
    test_add_basic();
    test_backpressure();
    test_inf_flags();
    test_round_and_notdone();
    test_reset_mid_wait();
    test_sub();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
